// File: rtl/anim_timer_bank_pkg.sv
// Shared defaults, channel-width helper and per-channel action type for the
// animation timer bank.
package anim_timer_bank_pkg;

    localparam int ANIM_TMR_CH      = 4;
    localparam int ANIM_TMR_CNT_W   = 32;
    localparam int ANIM_TMR_PRESC_W = 8;

    // Channel-select width, never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_STOP,
        ACT_START,
        ACT_TICK
    } ch_action_e;

endpackage

// File: rtl/anim_timer_ch.sv
// One timer channel: reload/mode registers, down-counter, running bit,
// registered expiry pulse and sticky pending flag.
module anim_timer_ch
    import anim_timer_bank_pkg::*;
#(
    parameter int CNT_W = ANIM_TMR_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             cfg_wen_in,
    input  logic [CNT_W-1:0] cfg_reload_in,
    input  logic             cfg_auto_in,
    input  logic             start_in,
    input  logic             stop_in,
    input  logic             pend_clr_in,
    output logic             active_out,
    output logic             expire_out,
    output logic             pending_out
);

    logic [CNT_W-1:0] reload_q, reload_d;
    logic             auto_q,   auto_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             run_q,    run_d;
    logic             exp_q,    exp_d;
    logic             pend_q,   pend_d;
    ch_action_e       action;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        action = ACT_HOLD;
        if (stop_in) begin
            action = ACT_STOP;
        end else if (start_in) begin
            action = ACT_START;
        end else if (tick_in && run_q) begin
            action = ACT_TICK;
        end
    end

    always_comb begin
        reload_d = reload_q;
        auto_d   = auto_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        exp_d    = 1'b0;
        pend_d   = pend_q & ~pend_clr_in;

        if (cfg_wen_in) begin
            reload_d = cfg_reload_in;
            auto_d   = cfg_auto_in;
        end

        // Start and auto-reload read reload_q, so a same-cycle config write is not yet visible.
        unique case (action)
            ACT_STOP: begin
                cnt_d = '0;
                run_d = 1'b0;
            end
            ACT_START: begin
                cnt_d = reload_q;
                run_d = (reload_q != '0);
            end
            ACT_TICK: begin
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (cnt_q == CNT_W'(1)) begin
                    exp_d  = 1'b1;
                    pend_d = 1'b1;
                    if (auto_q) begin
                        cnt_d = reload_q;
                        run_d = (reload_q != '0);
                    end else begin
                        cnt_d = '0;
                        run_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: the reload registers are ordinary flops here, so they are reset along with the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
            auto_q   <= 1'b0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            exp_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            reload_q <= reload_d;
            auto_q   <= auto_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            exp_q    <= exp_d;
            pend_q   <= pend_d;
        end
    end

    assign active_out  = |cnt_q;
    assign expire_out  = exp_q;
    assign pending_out = pend_q;

endmodule

// File: rtl/anim_timer_bank.sv
// Multi-channel down-counting timer bank with a shared free-running prescaler
// and an OR-reduced interrupt of the sticky pending flags.
module anim_timer_bank
    import anim_timer_bank_pkg::*;
#(
    parameter  int NUM_CH  = ANIM_TMR_CH,
    parameter  int CNT_W   = ANIM_TMR_CNT_W,
    parameter  int PRESC_W = ANIM_TMR_PRESC_W,
    localparam int CH_W    = ch_w(NUM_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_wen_in,
    input  logic [CH_W-1:0]    cfg_ch_in,
    input  logic [CNT_W-1:0]   cfg_reload_in,
    input  logic               cfg_auto_in,
    input  logic [NUM_CH-1:0]  start_in,
    input  logic [NUM_CH-1:0]  stop_in,
    input  logic [NUM_CH-1:0]  pend_clr_in,
    input  logic [PRESC_W-1:0] prescale_in,
    output logic [NUM_CH-1:0]  active_out,
    output logic [NUM_CH-1:0]  expire_out,
    output logic [NUM_CH-1:0]  pending_out,
    output logic               irq_out
);

    logic [PRESC_W-1:0] p_q, p_d;
    logic               tick;

    // Compare with >= so lowering prescale_in below p still ticks at once.
    assign tick = (p_q >= prescale_in);

    always_comb begin
        p_d = tick ? '0 : p_q + PRESC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] CH_IDX = CH_W'(i);

        anim_timer_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .tick_in       (tick),
            .cfg_wen_in    (cfg_wen_in && (cfg_ch_in == CH_IDX)),
            .cfg_reload_in (cfg_reload_in),
            .cfg_auto_in   (cfg_auto_in),
            .start_in      (start_in[i]),
            .stop_in       (stop_in[i]),
            .pend_clr_in   (pend_clr_in[i]),
            .active_out    (active_out[i]),
            .expire_out    (expire_out[i]),
            .pending_out   (pending_out[i])
        );
    end

    assign irq_out = |pending_out;

endmodule

// File: tb/tb_anim_timer_bank.sv
// Directed bench for anim_timer_bank: a vector table for single-cycle behaviour
// plus hand-written sequences for prescaled, auto-reload and reset corners.
module tb_anim_timer_bank;

    logic        clk;
    logic        rst_n;
    logic        cfg_wen;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_reload;
    logic        cfg_auto;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [3:0]  pclr;
    logic [7:0]  prescale;
    logic [3:0]  active;
    logic [3:0]  expire;
    logic [3:0]  pending;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    anim_timer_bank #(
        .NUM_CH  (4),
        .CNT_W   (32),
        .PRESC_W (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_wen_in    (cfg_wen),
        .cfg_ch_in     (cfg_ch),
        .cfg_reload_in (cfg_reload),
        .cfg_auto_in   (cfg_auto),
        .start_in      (start),
        .stop_in       (stop),
        .pend_clr_in   (pclr),
        .prescale_in   (prescale),
        .active_out    (active),
        .expire_out    (expire),
        .pending_out   (pending),
        .irq_out       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wen;
        logic [1:0]  ch;
        logic [31:0] reload;
        logic        auto_m;
        logic [3:0]  start;
        logic [3:0]  stop;
        logic [3:0]  clr;
        logic [3:0]  e_act;
        logic [3:0]  e_exp;
        logic [3:0]  e_pend;
        logic        e_irq;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(input string name, input logic wen, input logic [1:0] ch,
                                input logic [31:0] reload, input logic auto_m,
                                input logic [3:0] st, input logic [3:0] sp, input logic [3:0] cl,
                                input logic [3:0] ea, input logic [3:0] ee,
                                input logic [3:0] ep, input logic ei);
        vec_t v;
        v.name = name; v.wen = wen; v.ch = ch; v.reload = reload; v.auto_m = auto_m;
        v.start = st; v.stop = sp; v.clr = cl;
        v.e_act = ea; v.e_exp = ee; v.e_pend = ep; v.e_irq = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_wen = 1'b0;
        start   = '0;
        stop    = '0;
        pclr    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [31:0] r, input logic a);
        cfg_wen    = 1'b1;
        cfg_ch     = ch;
        cfg_reload = r;
        cfg_auto   = a;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t_last;
        int   n_exp;
        int   n_int;
        logic any_exp;
        logic seen;

        rst_n = 1'b1;
        cfg_ch = '0; cfg_reload = '0; cfg_auto = 1'b0;
        prescale = 8'd0;
        idle_inputs();

        vecs[0]  = mk("os_cfg",      1, 0, 3, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        vecs[1]  = mk("os_start",    0, 0, 0, 0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0);
        vecs[2]  = mk("os_cnt2",     0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0);
        vecs[3]  = mk("os_cnt1",     0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0);
        vecs[4]  = mk("os_expire",   0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 1);
        vecs[5]  = mk("os_after",    0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1);
        vecs[6]  = mk("os_clr",      0, 0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0);
        vecs[7]  = mk("pr_cfg4",     1, 2, 4, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        vecs[8]  = mk("pr_startstop",0, 0, 0, 0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        vecs[9]  = mk("pr_cfg9_start",1, 2, 9, 0, 4'h4, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 0);
        vecs[10] = mk("pr_cnt3",     0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 0);
        vecs[11] = mk("pr_cnt2",     0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 0);
        vecs[12] = mk("pr_cnt1",     0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 0);
        vecs[13] = mk("pr_expire4",  0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 1);
        vecs[14] = mk("pr_clr_start",0, 0, 0, 0, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 0);
        vecs[15] = mk("pr_stop",     0, 0, 0, 0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        vecs[16] = mk("r0_cfg",      1, 3, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        vecs[17] = mk("r0_start",    0, 0, 0, 0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        vecs[18] = mk("r0_idle",     0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);

        do_reset();
        #1;
        check("reset_active",  32'(active),  0);
        check("reset_expire",  32'(expire),  0);
        check("reset_pending", 32'(pending), 0);
        check("reset_irq",     32'(irq),     0);

        for (int i = 0; i < NV; i++) begin
            cfg_wen    = vecs[i].wen;
            cfg_ch     = vecs[i].ch;
            cfg_reload = vecs[i].reload;
            cfg_auto   = vecs[i].auto_m;
            start      = vecs[i].start;
            stop       = vecs[i].stop;
            pclr       = vecs[i].clr;
            step();
            check({vecs[i].name, "_active"},  32'(active),  32'(vecs[i].e_act));
            check({vecs[i].name, "_expire"},  32'(expire),  32'(vecs[i].e_exp));
            check({vecs[i].name, "_pending"}, 32'(pending), 32'(vecs[i].e_pend));
            check({vecs[i].name, "_irq"},     32'(irq),     32'(vecs[i].e_irq));
        end
        idle_inputs();

        // Auto-reload ch1, R=2, P=3: one expiry every 8 cycles.
        prescale = 8'd3;
        cfg(1, 2, 1);
        step();
        idle_inputs();
        start = 4'h2;
        step();
        start = '0;
        t_last = -1; n_exp = 0; n_int = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (expire[1]) begin
                if (t_last >= 0) begin
                    check("auto_period", 32'(c - t_last), 8);
                    n_int++;
                end else begin
                    check("auto_first_in_range", 32'(c < 8), 1);
                end
                t_last = c;
                n_exp++;
            end
        end
        check("auto_periods_seen", 32'(n_int >= 4), 1);
        seen = 1'b0;
        for (int c = 0; c < 16 && !seen; c++) begin
            step();
            seen = expire[1];
        end
        check("auto_resync", 32'(seen), 1);
        pclr = 4'h2;
        step();
        pclr = '0;
        check("auto_clr_mid", 32'(pending[1]), 0);
        check("auto_clr_mid_irq", 32'(irq), 0);
        for (int c = 0; c < 6; c++) step();
        pclr = 4'h2;
        step();
        pclr = '0;
        check("auto_clr_vs_set_exp", 32'(expire[1]), 1);
        check("auto_clr_vs_set_pend", 32'(pending[1]), 1);
        stop = 4'h2;
        pclr = 4'h2;
        step();
        idle_inputs();
        check("auto_stopped", 32'(active[1]), 0);

        // Auto-reload channel reconfigured to R=0 stops after the current expiry.
        prescale = 8'd0;
        cfg(1, 3, 1);
        step();
        idle_inputs();
        start = 4'h2;
        step();
        start = '0;
        cfg(1, 0, 1);
        step();
        idle_inputs();
        step();
        check("r0auto_k2_active", 32'(active[1]), 1);
        step();
        check("r0auto_expire", 32'(expire[1]), 1);
        check("r0auto_idle", 32'(active[1]), 0);
        any_exp = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            any_exp = any_exp | expire[1] | active[1];
        end
        check("r0auto_quiet", 32'(any_exp), 0);

        // Maximum reload: the first decrements are plain unsigned steps.
        cfg(0, 32'hFFFF_FFFF, 0);
        step();
        idle_inputs();
        start = 4'h1;
        step();
        start = '0;
        check("big_load", dut.g_ch[0].u_ch.cnt_q, 32'hFFFF_FFFF);
        for (int c = 0; c < 3; c++) step();
        check("big_dec3", dut.g_ch[0].u_ch.cnt_q, 32'hFFFF_FFFC);
        check("big_active", 32'(active[0]), 1);
        stop = 4'h1;
        step();
        idle_inputs();

        // Reset mid-count with R=5: immediate clear, no pulse afterwards.
        cfg(0, 5, 0);
        step();
        idle_inputs();
        start = 4'h1;
        step();
        start = '0;
        step();
        step();
        check("rst_precount_active", 32'(active[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_active", 32'(active), 0);
        check("rst_async_pend_irq", 32'({pending, expire, irq}), 0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        any_exp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            any_exp = any_exp | (|expire) | (|active);
        end
        check("rst_no_expire", 32'(any_exp), 0);
        start = 4'h1;
        step();
        start = '0;
        check("rst_reload_cleared", 32'(active[0]), 0);

        // Prescaler drop from 200 to 1 while p = 150 ticks on the next edge.
        prescale = 8'd200;
        do_reset();
        cfg(3, 1, 0);
        step();
        idle_inputs();
        start = 4'h8;
        step();
        start = '0;
        any_exp = 1'b0;
        for (int c = 0; c < 148; c++) begin
            step();
            any_exp = any_exp | (|expire);
        end
        check("presc_no_early_tick", 32'(any_exp), 0);
        check("presc_ch3_armed", 32'(active[3]), 1);
        prescale = 8'd1;
        step();
        check("presc_drop_tick", 32'(expire), 32'h8);
        check("presc_drop_idle", 32'(active[3]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/anim_timer_bank.md
# anim_timer_bank

Parametrised multi-channel down-counting timer bank, the generalised successor of the single 32-bit frame counter that drives seven-segment animation pacing. Each channel has:
- a reload register, loaded by a config write;
- one-shot or auto-reload mode;
- a shared programmable prescaler;
- a one-cycle expiry pulse, a sticky pending flag and a level "active" flag.

The "active" flag is equivalent to the legacy `|counter` signal. The bank sits beside the data cache. The control logic writes it through the config port, and processor sources read the flags as extra registers.

## Interface
Parameters:
- NUM_CH, 4, number of independent channels (1..16); CH_W = `CLOG2(NUM_CH)`, minimum 1
- CNT_W, 32, counter and reload width
- PRESC_W, 8, prescaler compare width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- cfg_wen_in  in  1  write reload and mode of channel cfg_ch_in
- cfg_ch_in  in  CH_W  target channel; writes with index >= NUM_CH are ignored
- cfg_reload_in  in  CNT_W  reload value
- cfg_auto_in  in  1  1 = auto-reload, 0 = one-shot
- start_in  in  NUM_CH  per-channel start/restart strobe
- stop_in  in  NUM_CH  per-channel stop strobe
- pend_clr_in  in  NUM_CH  per-channel pending clear
- prescale_in  in  PRESC_W  tick period minus one
- active_out  out  NUM_CH  counter of channel non-zero
- expire_out  out  NUM_CH  registered one-cycle expiry pulse
- pending_out  out  NUM_CH  sticky expiry flags
- irq_out  out  1  OR of pending_out

## Operation
- Reset clears all of the following:
  - reload registers, modes, counters and running bits;
  - prescaler count;
  - expire_out and pending_out, so irq_out = 0 and active_out = 0.
- Prescaler:
  - A free-running count p advances every cycle.
  - tick = (p >= prescale_in). On tick, p wraps to 0; otherwise p increments.
  - prescale_in = 0 gives a tick every cycle.
  - Lowering prescale_in below p produces a tick on the next cycle. No lock-up.
- Config write stores the reload value and mode only. It never starts or alters a running count.
  - A new reload value takes effect at the next start or the next auto-reload.
- Start:
  - counter <= reload and running <= (reload != 0).
  - Start on a running channel restarts it.
  - Start with reload 0 leaves the channel idle and produces no expiry.
- Stop: counter <= 0, running <= 0, no expiry. Stop wins over start in the same cycle.
- Count: on tick with running, counter decrements while counter > 1.
- When counter == 1 on a tick:
  - expire_out[i] <= 1 for one cycle and pending_out[i] <= 1.
  - One-shot: counter <= 0, running <= 0.
  - Auto-reload: counter <= stored reload. If that reload is 0, the channel stops.
- start_in and stop_in take priority over the tick update in the same cycle.
- Same-cycle config write and start on one channel: start uses the previously stored reload.
- Pending: set on expiry, cleared by pend_clr_in. Set wins over clear in the same cycle.
- active_out[i] = |counter[i], combinational from registers.

## Timing
- All state is updated on posedge clk. expire_out and pending_out are registered; active_out and irq_out are derived from registers.
- With prescale_in = 0, reload R and start sampled at edge k:
  - active_out is high from after edge k to edge k+R.
  - expire_out is high for exactly the cycle after edge k+R.
  - pending_out rises at edge k+R.
- With prescale_in = P, the period between expiries in auto-reload mode is R·(P+1) cycles.
- The first period after start may be shorter by up to P cycles, because the prescaler is not re-phased on start.
- Counter arithmetic is unsigned CNT_W. No underflow is possible because the decrement is gated at counter > 1.
- Asserting rst_n low mid-count clears the channel immediately, with no expiry pulse.

## Structure
- defs.vh gains `ANIM_TMR_CH` and `ANIM_TMR_CNT_W` defaults. `CLOG2 is reused.
- Sub-module anim_timer_ch holds one channel's state: reload, mode, counter, running, expire and pending. It is instantiated NUM_CH times via generate.
- The prescaler and irq reduction live in the top.

## Test plan
- Reset: hold rst_n low mid-count with R = 5 -> all outputs 0 asynchronously; no expire pulse after release.
- One-shot, ch0, R = 3, prescale_in = 0, start at edge k:
  - active_out[0] is high for 3 cycles;
  - expire_out[0] pulses once, in the cycle after edge k+3;
  - pending_out[0] = 1, irq_out = 1.
- Auto-reload, ch1, R = 2, prescale_in = 3:
  - expire_out[1] pulses every 8 cycles for at least 4 periods;
  - pend_clr_in[1] in the same cycle as an expiry leaves pending_out[1] = 1.
- Priorities:
  - start and stop together on ch2 -> idle, active_out[2] = 0.
  - Config R = 9 and start on ch2 in the same cycle, with stored R = 4 -> counts 4.
- Edge values:
  - Start with R = 0 -> no activity.
  - R = 0xFFFF_FFFF -> first decrements correct.
  - Auto-reload channel reconfigured to R = 0 -> stops after the current expiry.
  - prescale_in dropped from 200 to 1 while p = 150 -> tick on the next cycle.
